// File: rtl/sram_like_responder.sv
// Responder end of the sram-like req/addr_ok/data_ok bus, backed by a word RAM.
// Optional SRAM_RESP_RANDOM_STALL_EN adds LFSR-driven address back-pressure.
module sram_like_responder #(
    parameter int ADDR_W      = 12,
    parameter int LATENCY     = 1,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

    logic [31:0]            ram    [DEPTH];
    logic [31:0]            q_data [OUTSTANDING];
    logic [3:0]             q_cnt  [OUTSTANDING];
    logic [OUTSTANDING-1:0] q_vld;
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count;
    logic [ADDR_W-1:0]      idx;
    logic                   space_ok;
    logic                   push, pop;
    logic                   unused_ok;

    assign idx       = addr[ADDR_W+1:2];
    assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef SRAM_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        space_ok = (count < CNT_W'(OUTSTANDING));
        addr_ok  = space_ok && !lfsr[0];
    end
`else
    always_comb begin
        space_ok = (count < CNT_W'(OUTSTANDING));
        addr_ok  = space_ok;
    end
`endif

    always_comb begin
        data_ok = q_vld[head] && (q_cnt[head] == 4'd0);
        rdata   = data_ok ? q_data[head] : '0;
        push    = en && addr_ok;
        pop     = data_ok;
    end

    // RAM is deliberately not reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (push && wr && !reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i])
                    ram[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_vld <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                q_cnt[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                if (q_vld[i] && q_cnt[i] != 4'd0)
                    q_cnt[i] <= q_cnt[i] - 4'd1;
            end
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= next_ptr(head);
            end
            // Pushed slot is always empty, so it never collides with the decrement above.
            if (push) begin
                q_vld[tail]  <= 1'b1;
                q_cnt[tail]  <= CNT_INIT;
                q_data[tail] <= wr ? '0 : ram[idx];
                tail         <= next_ptr(tail);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized bench for sram_like_responder against a transaction-level model
// (response edge = max(accept+LATENCY, previous response+1)).
module tb_sram_like_responder;

    localparam int LAT  = 3;
    localparam int OUTS = 2;
    localparam int AW   = 12;

    logic        clk = 1'b0;
    logic        reset, en, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    sram_like_responder #(
        .ADDR_W(AW),
        .LATENCY(LAT),
        .OUTSTANDING(OUTS)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .wr(wr),
        .size(size),
        .wstrb(wstrb),
        .addr(addr),
        .wdata(wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata(rdata)
    );

    typedef struct {
        logic [31:0] data;
        int          pop_edge;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mem_m [0:(1<<AW)-1];
    logic [15:0] lfsr_m;
    int          edge_n    = 0;
    int          last_pop  = 0;
    int          n_vec     = 0;
    int          n_err     = 0;
    int          resp_seen = 0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // One bus cycle: check this cycle's outputs, drive inputs, advance the model at the edge.
    task automatic step(input bit rst, input bit e, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        output bit accepted, output bit obs_ok);
        bit          ok_m, dok_m;
        logic [31:0] rd_m;
        logic [AW-1:0] ix;
        resp_t       r;
        int          p;
        @(negedge clk);
        ok_m = (exp_q.size() < OUTS);
`ifdef SRAM_RESP_RANDOM_STALL_EN
        ok_m = ok_m && !lfsr_m[0];
`endif
        dok_m = (exp_q.size() > 0) && (exp_q[0].pop_edge == edge_n + 1);
        rd_m  = dok_m ? exp_q[0].data : 32'h0;
        check("addr_ok", {31'b0, addr_ok}, {31'b0, ok_m});
        check("data_ok", {31'b0, data_ok}, {31'b0, dok_m});
        check("rdata", rdata, rd_m);
        obs_ok = addr_ok;
        if (data_ok === 1'b1) begin
            last_rdata = rdata;
            resp_seen++;
        end
        reset = rst; en = e; wr = w; wstrb = s; addr = a; wdata = d;
        size  = 2'd2;
        @(posedge clk);
        edge_n++;
        accepted = 1'b0;
        if (rst) begin
            exp_q.delete();
            last_pop = 0;
            lfsr_m   = 16'hACE1;
        end else begin
            if (dok_m) void'(exp_q.pop_front());
            if (e && ok_m) begin
                accepted = 1'b1;
                ix = a[AW+1:2];
                r.data = w ? 32'h0 : mem_m[ix];
                p = edge_n + LAT;
                if (last_pop + 1 > p) p = last_pop + 1;
                r.pop_edge = p;
                last_pop = p;
                exp_q.push_back(r);
                if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (s[i]) mem_m[ix][8*i +: 8] = d[8*i +: 8];
                end
            end
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    endtask

    task automatic req(input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        bit acc, ok;
        int tries = 0;
        acc = 1'b0;
        while (!acc && tries < 64) begin
            step(1'b0, 1'b1, w, s, a, d, acc, ok);
            tries++;
        end
        check("req_accept_timeout", {31'b0, acc}, 32'h1);
    endtask

    task automatic idle(input int n);
        bit acc, ok;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc, ok);
    endtask

    initial begin
        bit acc, ok;
        int got, seen0;
        logic [2:0] ok_seq;
        logic [31:0] a;

        reset = 1'b1; en = 1'b0; wr = 1'b0; size = 2'd0;
        wstrb = 4'h0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        lfsr_m = 16'hACE1;

        // Prefill words 0..63 so every later read has a defined value.
        for (int i = 0; i < 64; i++)
            req(1'b1, 4'hF, 32'(i * 4), $urandom);
        idle(8);

        // Full-word write then read-back.
        req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        req(1'b0, 4'h0, 32'h10, 32'h0);
        idle(8);
        check("t1_readback", last_rdata, 32'hDEADBEEF);

        // Byte-lane merge.
        req(1'b1, 4'hF, 32'h20, 32'h11223344);
        req(1'b1, 4'b0100, 32'h20, 32'h00AA0000);
        req(1'b0, 4'h0, 32'h20, 32'h0);
        idle(8);
        check("t2_merge", last_rdata, 32'h11AA3344);

        // Back-to-back reads with en held: third request stalls until the first pop.
        got = 0;
        ok_seq = '0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            step(1'b0, 1'b1, 1'b0, 4'h0, 32'(got * 4), 32'h0, acc, ok);
            if (c < 3) ok_seq[2-c] = ok;
            if (acc) got++;
        end
        check("t3_all_accepted", 32'(got), 32'd3);
`ifndef SRAM_RESP_RANDOM_STALL_EN
        check("t3_addr_ok_seq", {29'b0, ok_seq}, 32'b110);
`endif
        idle(10);

        // Upper address bits ignored.
        req(1'b1, 4'hF, 32'h00004000, 32'h5A5A5A5A);
        req(1'b0, 4'h0, 32'h00000000, 32'h0);
        idle(8);
        check("t4_wrap", last_rdata, 32'h5A5A5A5A);

        // Reset with two reads pending: no responses afterwards, RAM preserved.
        req(1'b0, 4'h0, 32'h10, 32'h0);
        req(1'b0, 4'h0, 32'h20, 32'h0);
        seen0 = resp_seen;
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc, ok);
        idle(8);
        check("t5_no_resp_after_reset", 32'(resp_seen - seen0), 32'd0);
        req(1'b0, 4'h0, 32'h10, 32'h0);
        idle(8);
        check("t5_ram_kept", last_rdata, 32'hDEADBEEF);

        // Randomized mix with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            a[AW+1:2] = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 149) == 0)
                step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc, ok);
            else
                step(1'b0, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
                     4'($urandom), a, $urandom, acc, ok);
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Responder (slave) end of the sram-like req/addr_ok/data_ok interface that the fetch and memory stages drive.
- Backs the interface with an internal word-organised RAM.
- Accepts pipelined requests up to OUTSTANDING in flight and returns responses strictly in order after a fixed minimum LATENCY.
- Stands in for inst_sram/data_sram in core-level simulation and in the FPGA top ahead of the AXI bridge.

Parameters:
ADDR_W, 12, word-address bits; RAM holds 2^ADDR_W 32-bit words
LATENCY, 1, minimum cycles from address handshake to data_ok (legal range 1..15)
OUTSTANDING, 2, maximum accepted-but-unanswered requests (legal range 1..8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  request valid
wr  input  1  1 = write, 0 = read
size  input  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes
wstrb  input  4  byte write enables (write requests only)
addr  input  32  byte address
wdata  input  32  write data
addr_ok  output  1  request accepted this cycle when en=1
data_ok  output  1  response valid for exactly one cycle, oldest request first
rdata  output  32  read data qualified by data_ok

Behaviour:
- Reset state: queue empty, count=0, all entry counters cleared, addr_ok=1 (when the feature is off), data_ok=0, rdata=0. The RAM array is not reset; its contents survive reset.
- Handshake: a request is accepted when en && addr_ok at a rising edge.
- addr_ok = (count < OUTSTANDING). It is independent of en and of a same-cycle pop, so there is no full-bypass.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap. addr[1:0] and size are not checked. Misalignment is the requester's job.
- Accepted write: each RAM byte i is updated with wdata[8i+7:8i] where wstrb[i]=1, in the same edge as the handshake. A queue entry is still pushed and its response returns rdata=0.
- Accepted read: the RAM word is captured into the queue entry at the handshake edge, using the array state before that edge's write. Writes are only accepted one per cycle, so any earlier accepted write is always visible.
- Queue: circular buffer of OUTSTANDING entries, each holding {data[31:0], cnt[3:0]}. Pointers wrap modulo OUTSTANDING.
- On push: cnt = LATENCY-1.
- Every cycle: each valid entry with cnt != 0 decrements.
- data_ok = head valid && head.cnt == 0. rdata = head.data while data_ok=1, else 0.
- A pop occurs on every cycle with data_ok=1; the requester has no back-pressure.
- Response timing: with no queueing delay, data_ok rises exactly LATENCY cycles after the accept edge (LATENCY=1 means the next cycle).
- Throughput: a back-to-back stream sustains one response per cycle when OUTSTANDING >= LATENCY+1.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Reset mid-operation: all pending responses are discarded and no data_ok follows reset. Writes already accepted remain in the RAM.
- Requests presented while addr_ok=0 have no effect.

Optional Feature:
- Macro: SRAM_RESP_RANDOM_STALL_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. addr_ok = (count < OUTSTANDING) && !lfsr[0], giving pseudo-random address back-pressure that is reproducible from reset. Response timing and ordering are unchanged.
- When undefined: no LFSR exists, and addr_ok follows the rule above exactly.

Test Plan:
1. LATENCY=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> first data_ok has rdata 0; second data_ok one cycle after the read handshake with rdata 0xDEADBEEF.
2. Byte merge: word 0x20 = 0x11223344, then write wstrb 4'b0100 with wdata 0x00AA0000, then read -> rdata 0x11AA3344.
3. OUTSTANDING=2, LATENCY=3: hold en=1 with reads to 0x0, 0x4, 0x8 -> addr_ok=1 for the first two cycles and 0 on the third. data_ok arrives 3 cycles after each accept, in order. The third request is accepted on the cycle after the first pop.
4. Wrap: ADDR_W=12, write 0x5A5A5A5A to 0x00004000, read 0x00000000 -> rdata 0x5A5A5A5A.
5. Reset with 2 reads pending (LATENCY=3): assert reset for 1 cycle -> no data_ok for those reads, addr_ok=1 after reset, and earlier written data is still readable.
6. SRAM_RESP_RANDOM_STALL_EN defined: 1000 back-to-back reads -> addr_ok pattern matches the reference LFSR sequence from seed 0xACE1, and every accepted read gets exactly one in-order data_ok with correct data.
